ground_scroller: RTL

- Parametrised successor to the single-band ground renderer for the dinosaur game.
- Stores a ROWS x PATTERN_W bitmap and scrolls it horizontally once per frame, by a variable speed that ramps up during play.
- Emits a 1-bit pixel for the VGA mixer on a fixed 2-cycle pipeline.
- Sits between the VGA timing generator (row/col/fresh) and the game controller (game_status/crash).

---
 rtl/game_pkg.sv | 26 ++
 rtl/ground_pattern_rom.sv | 25 ++
 rtl/ground_scroller.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the dinosaur-game ground band: FSM states,
// default geometry and the ground bitmap ROM contents.
package game_pkg;

  localparam int GROUND_PATTERN_W = 160;
  localparam int GROUND_ROWS      = 8;
  localparam int GROUND_ROW_BASE  = 400;

  typedef enum logic [1:0] {IDLE, RUN, HALT} ground_state_t;

  typedef logic [GROUND_ROWS-1:0][GROUND_PATTERN_W-1:0] ground_bitmap_t;

  // Pebble/crack texture; bit 0 of each row is the leftmost pixel.
  function automatic ground_bitmap_t make_ground_bitmap();
    ground_bitmap_t bm;
    for (int r = 0; r < GROUND_ROWS; r++) begin
      for (int c = 0; c < GROUND_PATTERN_W; c++) begin
        bm[r][c] = (((c * (2 * r + 3)) + r) % 11) < 4;
      end
    end
    return bm;
  endfunction

  localparam ground_bitmap_t GROUND_BITMAP = make_ground_bitmap();

endpackage

// File: rtl/ground_pattern_rom.sv
// Stage 2 of the ground pixel pipeline: registered 1-bit read of the
// ground bitmap, forced to 0 outside the ground band.
module ground_pattern_rom
  import game_pkg::*;
#(
  parameter int ROWS      = GROUND_ROWS,
  parameter int PATTERN_W = GROUND_PATTERN_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic [$clog2(ROWS)-1:0]      i_row,
  input  logic [$clog2(PATTERN_W)-1:0] i_col,
  output logic                         o_px
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_px <= 1'b0;
    end else begin
      o_px <= i_en ? GROUND_BITMAP[i_row][i_col] : 1'b0;
    end
  end

endmodule

// File: rtl/ground_scroller.sv
// Scrolling ground band: frame-ticked scroll FSM plus 2-cycle pixel pipeline.
// Define GROUND_ACCEL_EN to enable the speed ramp during RUN.
module ground_scroller
  import game_pkg::*;
#(
  parameter int PATTERN_W    = GROUND_PATTERN_W,
  parameter int ROWS         = GROUND_ROWS,
  parameter int ROW_BASE     = GROUND_ROW_BASE,
  parameter int SPEED_INIT   = 4,
  parameter int SPEED_MAX    = 12,
  parameter int ACCEL_FRAMES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [8:0]                   row_addr,
  input  logic [9:0]                   col_addr,
  input  logic                         fresh,
  input  logic                         game_status,
  input  logic                         crash,
  output logic [$clog2(PATTERN_W)-1:0] ground_position,
  output logic [3:0]                   speed,
  output logic                         px
);

  localparam int POS_W = $clog2(PATTERN_W);
  localparam int ROW_W = $clog2(ROWS);
  localparam int SUM_W = POS_W + 1;
  localparam logic [8:0] ROW_LO = 9'(ROW_BASE);
  localparam logic [8:0] ROW_HI = 9'(ROW_BASE + ROWS);
  localparam logic [3:0] SPEED_RST = 4'(SPEED_INIT);

  if (PATTERN_W <= SPEED_MAX || ACCEL_FRAMES < 2) begin : g_bad_params
    $error("ground_scroller: need PATTERN_W > SPEED_MAX and ACCEL_FRAMES >= 2");
  end

  ground_state_t    r_state;
  logic [POS_W-1:0] r_pos;
  logic [3:0]       r_speed;
  logic             r_fresh_d;
  logic             w_tick;
  logic [SUM_W-1:0] w_pos_sum;
  logic [POS_W-1:0] w_pos_next;

  assign w_tick     = fresh & ~r_fresh_d;
  // Speed never exceeds PATTERN_W, so one conditional subtract is a full wrap.
  assign w_pos_sum  = {1'b0, r_pos} + SUM_W'(r_speed);
  assign w_pos_next = (w_pos_sum >= SUM_W'(PATTERN_W))
                    ? POS_W'(w_pos_sum - SUM_W'(PATTERN_W))
                    : w_pos_sum[POS_W-1:0];

`ifdef GROUND_ACCEL_EN
  localparam int CNT_W = $clog2(ACCEL_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEL_FRAMES - 1);
  logic [CNT_W-1:0] r_frame_cnt;
  logic [3:0]       w_speed_inc;
  assign w_speed_inc = (r_speed >= 4'(SPEED_MAX)) ? r_speed : r_speed + 4'd1;
`endif

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking would let r_pos see its own update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_pos     <= '0;
      r_speed   <= SPEED_RST;
      r_fresh_d <= 1'b0;
`ifdef GROUND_ACCEL_EN
      r_frame_cnt <= '0;
`endif
    end else begin
      r_fresh_d <= fresh;
      case (r_state)
        IDLE: begin
          r_speed <= SPEED_RST;
`ifdef GROUND_ACCEL_EN
          r_frame_cnt <= '0;
`endif
          if (game_status) begin
            r_state <= RUN;
            r_pos   <= '0;
          end
        end
        RUN: begin
          if (!game_status) begin
            r_state <= IDLE;
            r_speed <= SPEED_RST;
          end else if (crash) begin
            r_state <= HALT;
          end else if (w_tick) begin
            r_pos <= w_pos_next;
`ifdef GROUND_ACCEL_EN
            if (r_frame_cnt == CNT_LAST) begin
              r_frame_cnt <= '0;
              r_speed     <= w_speed_inc;
            end else begin
              r_frame_cnt <= r_frame_cnt + CNT_W'(1);
            end
`endif
          end
        end
        HALT: begin
          if (!game_status) begin
            r_state <= IDLE;
            r_speed <= SPEED_RST;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ground_position = r_pos;
  assign speed           = r_speed;

  // Stage 1: band test, row offset and wrapped column index.
  logic             r_in_band;
  logic [ROW_W-1:0] r_row;
  logic [POS_W-1:0] r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_band <= 1'b0;
      r_row     <= '0;
      r_idx     <= '0;
    end else begin
      r_in_band <= (row_addr >= ROW_LO) && (row_addr < ROW_HI);
      r_row     <= ROW_W'(row_addr - ROW_LO);
      r_idx     <= POS_W'((11'(col_addr) + 11'(r_pos)) % 11'(PATTERN_W));
    end
  end

  ground_pattern_rom #(
    .ROWS      (ROWS),
    .PATTERN_W (PATTERN_W)
  ) u_rom (
    .clk   (clk),
    .rst   (rst),
    .i_en  (r_in_band),
    .i_row (r_row),
    .i_col (r_idx),
    .o_px  (px)
  );

endmodule
